// File: rtl/fifo_spi_bridge.sv
// Prefetches words from an upstream FIFO into a small circular buffer and
// hands them one at a time to an SPI transmitter, with optional framing.
module fifo_spi_bridge #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4,
  parameter int RD_LAT    = 1,
  parameter int FRAME_LEN = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           flush,
  input  logic                           fifo_is_empty,
  output logic                           fifo_read_en,
  input  logic [DATA_W-1:0]              datain,
  output logic                           spi_tx_en,
  output logic [DATA_W-1:0]              dataout,
  input  logic                           spi_tx_done,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_level,
  output logic [15:0]                    frame_cnt,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int CW = LW + 2;
  localparam logic [31:0] FL = FRAME_LEN;

  // state | meaning
  // IDLE  | no word on the SPI link; launch when enabled and buffer non-empty
  // SEND  | spi_tx_en high, dataout held until spi_tx_done
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [RD_LAT-1:0] rd_pipe;
  logic [CW-1:0]     in_flight, committed;
  logic              issue, capture, launch, complete, frame_wrap;
  logic [15:0]       frame_inc;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(rd_pipe[i]);
  end

  // Space is reserved for every read already issued, so the buffer cannot overflow.
  assign committed = CW'(buf_level) + in_flight + CW'(fifo_read_en);
  assign issue     = enable && !fifo_is_empty && !flush && !fifo_read_en &&
                     (committed < CW'(BUF_DEPTH));
  assign capture   = rd_pipe[RD_LAT-1];

  assign frame_inc  = frame_cnt + 16'd1;
  assign frame_wrap = (FL != 32'd0) && ({16'd0, frame_inc} == FL);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (buf_level != '0) && !flush) begin
          launch    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (spi_tx_done) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_read_en <= 1'b0;
      rd_pipe      <= '0;
    end else begin
      fifo_read_en <= issue;
      if (flush) begin
        rd_pipe <= '0;
      end else begin
        rd_pipe[0] <= fifo_read_en;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture && !flush) mem[wr_ptr] <= datain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_level <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_level <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (launch)  rd_ptr <= rd_ptr + 1'b1;
      case ({capture, launch})
        2'b10:   buf_level <= buf_level + 1'b1;
        2'b01:   buf_level <= buf_level - 1'b1;
        default: buf_level <= buf_level;
      endcase
    end
  end

  // A completion landing on a flush edge is not counted; flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout    <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (launch) dataout <= mem[rd_ptr];
      if (flush) begin
        frame_cnt <= '0;
      end else if (complete) begin
        if (frame_wrap) begin
          frame_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          frame_cnt <= frame_inc;
        end
      end
    end
  end

  assign spi_tx_en = (state == SEND);
  assign busy      = spi_tx_en || fifo_read_en || (|rd_pipe) || (buf_level != '0);

endmodule

// File: tb/tb_fifo_spi_bridge.sv
// Bench for fifo_spi_bridge: instance 0 (RD_LAT=1, FRAME_LEN=3) and
// instance 1 (RD_LAT=2, free-running frame counter) with FIFO and SPI models.
`timescale 1ns/1ps
module tb_fifo_spi_bridge;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LVW   = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n, enable, flush;
  always #5 clk = ~clk;

  logic [1:0]          rd, tx, fdone, busy, empty;
  logic [1:0]          done = 2'b00;
  logic [1:0]          hold = 2'b00;
  logic [1:0][DW-1:0]  dout;
  logic [1:0][LVW-1:0] lvl;
  logic [1:0][15:0]    fcnt;
  logic [DW-1:0]       din_a, din_b, dly_b;

  fifo_spi_bridge #(.DATA_W(DW), .BUF_DEPTH(DEPTH), .RD_LAT(1), .FRAME_LEN(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_is_empty(empty[0]), .fifo_read_en(rd[0]), .datain(din_a),
    .spi_tx_en(tx[0]), .dataout(dout[0]), .spi_tx_done(done[0]),
    .buf_level(lvl[0]), .frame_cnt(fcnt[0]), .frame_done(fdone[0]), .busy(busy[0]));

  fifo_spi_bridge #(.DATA_W(DW), .BUF_DEPTH(DEPTH), .RD_LAT(2), .FRAME_LEN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_is_empty(empty[1]), .fifo_read_en(rd[1]), .datain(din_b),
    .spi_tx_en(tx[1]), .dataout(dout[1]), .spi_tx_done(done[1]),
    .buf_level(lvl[1]), .frame_cnt(fcnt[1]), .frame_done(fdone[1]), .busy(busy[1]));

  int total = 0, bad = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // upstream FIFO models
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0, rd_cnt_a = 0, rd_cnt_b = 0;
  assign empty[0] = (rp_a == wp_a);
  assign empty[1] = (rp_b == wp_b);

  always @(posedge clk) begin
    if (rd[0]) begin
      din_a    <= mem_a[rp_a];
      rp_a     <= rp_a + 1;
      rd_cnt_a <= rd_cnt_a + 1;
    end else begin
      din_a <= 8'hEE;
    end
  end

  always @(posedge clk) begin
    din_b <= dly_b;
    if (rd[1]) begin
      dly_b    <= mem_b[rp_b];
      rp_b     <= rp_b + 1;
      rd_cnt_b <= rd_cnt_b + 1;
    end else begin
      dly_b <= 8'hEE;
    end
  end

  // SPI transmitter model: done pulse 3 cycles after spi_tx_en rises
  int rcnt [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!tx[k]) begin
        rcnt[k] <= 0;
        done[k] <= 1'b0;
      end else if (done[k]) begin
        done[k] <= 1'b0;
      end else if (!hold[k]) begin
        if (rcnt[k] == 2) done[k] <= 1'b1;
        rcnt[k] <= rcnt[k] + 1;
      end
    end
  end

  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];

  function automatic int pop_exp(input int k);
    if (k == 0) begin
      if (exp_a.size() == 0) return -1;
      return int'(exp_a.pop_front());
    end
    if (exp_b.size() == 0) return -1;
    return int'(exp_b.pop_front());
  endfunction

  // monitor / scoreboard
  logic [1:0]         prev_rd = 2'b00, prev_tx = 2'b00;
  logic [1:0][DW-1:0] prev_dout;
  int sent [2];
  int fd_cnt [2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n === 1'b1) begin
        if (rd[k]) chk($sformatf("rd_b2b%0d", k), int'(prev_rd[k]), 0);
        chk($sformatf("lvl_le_depth%0d", k), int'(int'(lvl[k]) <= DEPTH), 1);
        if (tx[k] && !prev_tx[k]) begin
          chk($sformatf("sb_data%0d", k), int'(dout[k]), pop_exp(k));
          sent[k] <= sent[k] + 1;
        end
        if (tx[k] && prev_tx[k]) chk($sformatf("dout_hold%0d", k), int'(dout[k]), int'(prev_dout[k]));
        if (fdone[k]) begin
          chk($sformatf("fdone_wrap%0d", k), int'(fcnt[k]), 0);
          fd_cnt[k] <= fd_cnt[k] + 1;
        end
      end
      prev_rd[k]   <= rd[k];
      prev_tx[k]   <= tx[k];
      prev_dout[k] <= dout[k];
    end
  end

  task automatic load(input int k, input int n, input int first, input bit push);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = (first < 0) ? DW'($urandom_range(0, 255)) : DW'(first * (i + 1));
      if (k == 0) begin
        mem_a[wp_a] = w;
        wp_a = wp_a + 1;
        if (push) exp_a.push_back(w);
      end else begin
        mem_b[wp_b] = w;
        wp_b = wp_b + 1;
        if (push) exp_b.push_back(w);
      end
    end
  endtask

  function automatic int outs(input int k);
    return int'({rd[k], tx[k], dout[k], lvl[k], fcnt[k], fdone[k], busy[k]});
  endfunction

  task automatic drop_fifo();
    wp_a = rp_a;
    wp_b = rp_b;
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    drop_fifo();
    repeat (3) @(negedge clk);
    chk("rst_zero_a", outs(0), 0);
    chk("rst_zero_b", outs(1), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy != 2'b00) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, int'(n < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int n;
    int first;
    int fcnt_a;
    int fdone_a;
    int fcnt_b;
  } vec_t;
  vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0a, s0b, f0a, f0b, r0a, r0b, base, n;
    vecs[0] = '{n: 3, first: 17, fcnt_a: 0, fdone_a: 1, fcnt_b: 3};
    vecs[1] = '{n: 7, first: -1, fcnt_a: 1, fdone_a: 2, fcnt_b: 7};
    vecs[2] = '{n: 1, first: -1, fcnt_a: 1, fdone_a: 0, fcnt_b: 1};
    vecs[3] = '{n: 6, first: -1, fcnt_a: 0, fdone_a: 2, fcnt_b: 6};
    enable = 1'b1;
    flush  = 1'b0;
    do_reset();

    for (int r = 0; r < 4; r++) begin
      do_reset();
      s0a = sent[0]; s0b = sent[1]; f0a = fd_cnt[0]; f0b = fd_cnt[1];
      load(0, vecs[r].n, vecs[r].first, 1'b1);
      load(1, vecs[r].n, vecs[r].first, 1'b1);
      wait_idle($sformatf("row%0d", r));
      chk("row_sent_a", sent[0] - s0a, vecs[r].n);
      chk("row_sent_b", sent[1] - s0b, vecs[r].n);
      chk("row_fcnt_a", int'(fcnt[0]), vecs[r].fcnt_a);
      chk("row_fdone_a", fd_cnt[0] - f0a, vecs[r].fdone_a);
      chk("row_fcnt_b", int'(fcnt[1]), vecs[r].fcnt_b);
      chk("row_fdone_b", fd_cnt[1] - f0b, 0);
      chk("row_busy", int'(busy), 0);
    end

    // back-pressure: SPI never completes, buffer fills and reads stop
    do_reset();
    hold = 2'b11;
    r0a = rd_cnt_a; r0b = rd_cnt_b;
    load(0, 10, -1, 1'b1);
    load(1, 10, -1, 1'b1);
    repeat (40) @(negedge clk);
    chk("bp_reads_a", rd_cnt_a - r0a, 5);
    chk("bp_reads_b", rd_cnt_b - r0b, 5);
    chk("bp_lvl_a", int'(lvl[0]), DEPTH);
    chk("bp_lvl_b", int'(lvl[1]), DEPTH);
    repeat (10) @(negedge clk);
    chk("bp_reads_still_a", rd_cnt_a - r0a, 5);
    chk("bp_reads_still_b", rd_cnt_b - r0b, 5);
    hold = 2'b00;
    wait_idle("bp");

    // flush with one word in SEND, two buffered, one read in flight
    chk("fl_pre_fcnt", int'(fcnt[0]), 1);
    hold = 2'b01;
    base = wp_a;
    load(0, 10, -1, 1'b0);
    exp_a.push_back(mem_a[base]);
    for (int i = 4; i < 10; i++) exp_a.push_back(mem_a[base + i]);
    n = 0;
    while (!(lvl[0] == LVW'(2) && rd[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fl_reach", int'(n < 100), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_lvl", int'(lvl[0]), 0);
    chk("fl_fcnt", int'(fcnt[0]), 0);
    chk("fl_tx_held", int'(tx[0]), 1);
    chk("fl_no_issue", int'(rd[0]), 0);
    hold = 2'b00;
    wait_idle("flush");
    chk("fl_post_fcnt", int'(fcnt[0]), 1);

    // flush on the same edge as spi_tx_done
    do_reset();
    load(0, 1, -1, 1'b1);
    n = 0;
    while (!done[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fd_reach", int'(n < 100), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fd_fcnt", int'(fcnt[0]), 0);
    chk("fd_tx", int'(tx[0]), 0);
    wait_idle("fd");

    // asynchronous reset in the middle of a word
    do_reset();
    hold = 2'b01;
    load(0, 6, -1, 1'b1);
    n = 0;
    while (!tx[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ar_reach", int'(n < 100), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tx", int'(tx[0]), 0);
    chk("ar_zero_a", outs(0), 0);
    hold = 2'b00;
    drop_fifo();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s0a = sent[0];
    load(0, 4, -1, 1'b1);
    wait_idle("ar");
    chk("ar_sent", sent[0] - s0a, 4);
    chk("ar_fcnt", int'(fcnt[0]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
